// File: rtl/aoi_exhaustive_checker_pkg.sv
// Shared constants and FSM encoding for the exhaustive AOI response checker.
package aoi_exhaustive_checker_pkg;

  localparam int N_IN         = 5;
  localparam int NUM_PATTERNS = 2 ** N_IN;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/aoi_exhaustive_checker_aoi_golden.sv
// Golden reference for the 5-input AOI cell: y = ~((x1&x2)|(x3&x4&x5)).
module aoi_golden (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic x5,
  output logic y
);

  assign y = ~((x1 & x2) | (x3 & x4 & x5));

endmodule

// File: rtl/aoi_exhaustive_checker.sv
// Sweeps all input patterns onto an external AOI cell, samples its output after
// a settle time and accumulates mismatches against the golden model.
module aoi_exhaustive_checker #(
  parameter int N_IN   = aoi_exhaustive_checker_pkg::N_IN,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             cut_y,
  output logic [N_IN-1:0]  pattern,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail,
  output logic             fail_valid
);

  import aoi_exhaustive_checker_pkg::*;

  localparam int               SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_PAT    = {N_IN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [N_IN-1:0]  pattern_q, pattern_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] err_count_q, err_count_d, err_next;
  logic [N_IN-1:0]  first_fail_q, first_fail_d;
  logic             fail_valid_q, fail_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             golden_y;
  logic             mismatch;

  aoi_golden u_golden (
    .x1 (pattern_q[4]),
    .x2 (pattern_q[3]),
    .x3 (pattern_q[2]),
    .x4 (pattern_q[1]),
    .x5 (pattern_q[0]),
    .y  (golden_y)
  );

  // Case inequality so that an undriven or X CUT output is scored as a failure.
  assign mismatch = (cut_y !== golden_y);

  always_comb begin
    state_d      = state_q;
    pattern_d    = pattern_q;
    settle_d     = settle_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    fail_valid_d = fail_valid_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_next     = err_count_q;
    if (mismatch && (err_count_q != CNT_MAX)) begin
      err_next = err_count_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_APPLY;
          pattern_d    = '0;
          settle_d     = '0;
          err_count_d  = '0;
          first_fail_d = '0;
          fail_valid_d = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      ST_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_SAMPLE: begin
        err_count_d = err_next;
        if (mismatch && !fail_valid_q) begin
          first_fail_d = pattern_q;
          fail_valid_d = 1'b1;
        end
        // pass reflects the count including this final comparison.
        if (pattern_q == LAST_PAT) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          state_d   = ST_APPLY;
          pattern_d = pattern_q + N_IN'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pattern_q    <= '0;
      settle_q     <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pattern_q    <= pattern_d;
      settle_q     <= settle_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      fail_valid_q <= fail_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign pattern    = pattern_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;
  assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_aoi_exhaustive_checker.sv
// Bench for aoi_exhaustive_checker: two instances (SETTLE=1 and SETTLE=3) driven
// by a modelled CUT with directed and random fault maps.
module tb_aoi_exhaustive_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, start3;
  logic        cut_y1, cut_y3;
  logic [4:0]  pattern1, pattern3, ff1, ff3;
  logic [5:0]  err1, err3;
  logic        busy1, done1, pass1, fv1;
  logic        busy3, done3, pass3, fv3;
  int          mode1, mode3;
  logic [31:0] mask1, mask3;
  int          checks = 0;
  int          errors = 0;

  // AOI truth: x1&x2 covers patterns 24..31, x3&x4&x5 covers every p with p%8==7.
  function automatic logic golden(int p);
    return !((p >= 24) || (p % 8 == 7));
  endfunction

  // CUT model: 0 correct, 1 stuck-at-1, 2 stuck-at-0, 3 missing 3-input term, 4 flip by mask.
  function automatic logic cut_model(int mode, logic [31:0] mask, int p);
    case (mode)
      0:       return golden(p);
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return !(p >= 24);
      default: return golden(p) ^ mask[p];
    endcase
  endfunction

  function automatic void sweep_model(int mode, logic [31:0] mask, output int n, output int first);
    n = 0;
    first = 0;
    for (int p = 31; p >= 0; p--) begin
      if (cut_model(mode, mask, p) != golden(p)) begin
        n++;
        first = p;
      end
    end
  endfunction

  assign cut_y1 = cut_model(mode1, mask1, int'(pattern1));
  assign cut_y3 = cut_model(mode3, mask3, int'(pattern3));

  aoi_exhaustive_checker #(.N_IN(5), .SETTLE(1), .CNT_W(6)) dut (
    .clock(clk), .reset(rst_n), .start(start1), .cut_y(cut_y1),
    .pattern(pattern1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .fail_valid(fv1)
  );

  aoi_exhaustive_checker #(.N_IN(5), .SETTLE(3), .CNT_W(6)) dut3 (
    .clock(clk), .reset(rst_n), .start(start3), .cut_y(cut_y3),
    .pattern(pattern3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail(ff3), .fail_valid(fv3)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero1(string tag);
    check({tag, ".pattern"}, 32'(pattern1), 0);
    check({tag, ".err_count"}, 32'(err1), 0);
    check({tag, ".first_fail"}, 32'(ff1), 0);
    check({tag, ".busy"}, 32'(busy1), 0);
    check({tag, ".done"}, 32'(done1), 0);
    check({tag, ".pass"}, 32'(pass1), 0);
    check({tag, ".fail_valid"}, 32'(fv1), 0);
  endtask

  task automatic check_results1(string tag, int mode, logic [31:0] mask);
    int n, first;
    sweep_model(mode, mask, n, first);
    check({tag, ".err_count"}, 32'(err1), 32'(n));
    check({tag, ".first_fail"}, 32'(ff1), 32'(first));
    check({tag, ".fail_valid"}, 32'(fv1), 32'(n > 0));
    check({tag, ".pass"}, 32'(pass1), 32'(n == 0));
    check({tag, ".pattern"}, 32'(pattern1), 31);
    check({tag, ".busy"}, 32'(busy1), 0);
    $display("sweep %s: mode=%0d err_count=%0d first_fail=%0d pass=%0d", tag, mode, err1, ff1, pass1);
  endtask

  // One pulsed sweep on the SETTLE=1 instance; done rises at start edge + 64,
  // which is the 65th falling edge counted from the start edge.
  task automatic run1(string tag, int mode, logic [31:0] mask);
    int cycles;
    mode1 = mode;
    mask1 = mask;
    @(negedge clk);
    start1 = 1'b1;
    cycles = 0;
    while (cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        start1 = 1'b0;
        check({tag, ".busy_after_start"}, 32'(busy1), 1);
        check({tag, ".err_cleared"}, 32'(err1), 0);
      end
      if (done1) break;
    end
    check({tag, ".done_cycle"}, 32'(cycles), 65);
    check_results1(tag, mode, mask);
  endtask

  initial begin
    int cycles, n, first, prev, run, bad, trans;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    mode1  = 0;
    mode3  = 0;
    mask1  = '0;
    mask3  = '0;
    repeat (3) @(negedge clk);
    check_all_zero1("reset");
    check("reset.dut3_busy", 32'(busy3), 0);
    rst_n = 1'b1;

    run1("correct", 0, '0);
    run1("stuck1", 1, '0);
    run1("stuck0", 2, '0);
    run1("no3term", 3, '0);
    for (int r = 0; r < 3; r++) run1("random", 4, $urandom);
    run1("allbad", 4, 32'hFFFF_FFFF);

    // start mid-sweep must be ignored; reset mid-sweep must clear everything.
    mode1 = 4;
    mask1 = 32'hFFFF_FFFF;
    @(negedge clk);
    start1 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start1 = (c == 10);
      if (c == 12) check("busystart.pattern_c12", 32'(pattern1), 5);
    end
    check("busystart.pattern_c30", 32'(pattern1), 14);
    check("busystart.err_c30", 32'(err1), 14);
    start1 = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_all_zero1("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run1("after_reset", 0, '0);

    // start held high: done lasts one cycle then the sweep relaunches.
    mode1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    cycles = 0;
    while (cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (done1) break;
    end
    check("held.done_cycle", 32'(cycles), 65);
    @(negedge clk);
    check("held.done_one_cycle", 32'(done1), 0);
    check("held.relaunch_busy", 32'(busy1), 1);
    start1 = 1'b0;
    cycles = 0;
    while (!done1 && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    check("held.second_pass", 32'(pass1), 1);

    // SETTLE=3 instance: each pattern held 4 cycles, done 128 edges after start.
    for (int s = 0; s < 2; s++) begin
      mode3 = (s == 0) ? 4 : 0;
      mask3 = $urandom | 32'h1000;
      @(negedge clk);
      start3 = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      cycles = 1;
      check("settle3.err_cleared", 32'(err3), 0);
      prev = int'(pattern3);
      run = 1;
      bad = 0;
      trans = 0;
      while (!done3 && cycles < 600) begin
        @(negedge clk);
        cycles++;
        if (done3) break;
        if (int'(pattern3) == prev) begin
          run++;
        end else begin
          trans++;
          if (run != 4 || int'(pattern3) != prev + 1) bad++;
          prev = int'(pattern3);
          run = 1;
        end
      end
      check("settle3.done_cycle", 32'(cycles), 129);
      check("settle3.hold_violations", 32'(bad), 0);
      check("settle3.transitions", 32'(trans), 31);
      sweep_model(mode3, mask3, n, first);
      check("settle3.err_count", 32'(err3), 32'(n));
      check("settle3.first_fail", 32'(ff3), 32'(first));
      check("settle3.pass", 32'(pass3), 32'(n == 0));
      $display("sweep settle3 #%0d: mode=%0d err_count=%0d first_fail=%0d pass=%0d", s, mode3, err3, ff3, pass3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aoi_exhaustive_checker.md
Name: aoi_exhaustive_checker

Overview:
Response-side companion to the 5-input AOI cell, y = ~((x1&x2)|(x3&x4&x5)). It drives all 32 input patterns onto an external cell under test (CUT) and samples the CUT output after a programmable settle time. It compares each sample against an internal golden model and reports the pass/fail result, the error count and the first failing pattern. It sits beside the AOI cell as a self-test harness, usable in simulation and as synthesizable on-chip BIST.

Parameters:
N_IN, 5, number of CUT inputs; pattern space is 2**N_IN (fixed 5 for the AOI function).
SETTLE, 1, number of cycles a pattern is held before sampling; must be >= 1.
CNT_W, 6, err_count width; must hold 0..2**N_IN.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  level-sampled request to begin a sweep; honoured only in IDLE or DONE.
cut_y  input  1  CUT output for the currently driven pattern.
pattern  output  N_IN  {x1,x2,x3,x4,x5} driven to the CUT; x1 is the MSB.
busy  output  1  high while in APPLY or SAMPLE.
done  output  1  high in DONE; holds until the next start.
pass  output  1  valid only when done=1; high iff err_count==0.
err_count  output  CNT_W  number of mismatching patterns in the current or last sweep.
first_fail  output  N_IN  lowest pattern that mismatched; valid when fail_valid=1.
fail_valid  output  1  high once any mismatch has been recorded in the sweep.

Behaviour:
- Reset (reset=0, asynchronous) puts the FSM in IDLE. All outputs go to 0: pattern, err_count, first_fail, busy, done, pass and fail_valid.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE/DONE with start=1 at an edge: go to APPLY; pattern<=0; err_count<=0; fail_valid<=0; first_fail<=0; done<=0; pass<=0; settle counter<=0.
- APPLY: pattern is held stable. Stay for exactly SETTLE cycles, then go to SAMPLE.
- SAMPLE: one cycle. On the edge leaving SAMPLE, compare cut_y to golden(pattern).
  - On mismatch: err_count increments by 1 and does not wrap (max 32 fits in 6 bits). If fail_valid=0, first_fail<=pattern and fail_valid<=1.
  - If pattern==31: go to DONE; done<=1; pass<=(final err_count==0), which includes the last comparison.
  - Otherwise: pattern<=pattern+1 and go to APPLY.
- Each pattern is held SETTLE+1 cycles. done rises 32*(SETTLE+1) edges after the start edge (64 with SETTLE=1). pattern holds 31 in DONE.
- start while busy is ignored; no restart and no counter disturbance.
- start held high continuously re-launches the sweep on the edge after DONE is entered; done is high for one cycle.
- cut_y is X/Z: the comparison uses !== semantics in the golden compare, so a non-0/1 value counts as a mismatch.
- Reset asserted mid-sweep aborts immediately to IDLE with all outputs 0. No partial results are retained.

Decomposition:
- Shared constants (include/package): N_IN, NUM_PATTERNS=32, state encodings for IDLE/APPLY/SAMPLE/DONE.
- One combinational sub-module, aoi_golden (5 inputs, 1 output), implementing y = ~((x1&x2)|(x3&x4&x5)). It is the single source of truth for the expected value.
- The checker top holds the FSM, pattern counter, settle counter, error counter and first-fail register.

Test Plan:
- Correct AOI model as CUT, SETTLE=1, start pulse -> done after 64 cycles; pass=1; err_count=0; fail_valid=0; pattern=31.
- CUT output stuck-at-1 -> err_count=11 (patterns 7, 15, 23, 24..31); first_fail=5'b00111; pass=0.
- CUT output stuck-at-0 -> err_count=21; first_fail=5'b00000; fail_valid=1; pass=0.
- CUT = ~(x1&x2) only (missing 3-input term) -> err_count=3 (patterns 7, 15, 23); first_fail=7.
- Pulse start at cycle 10 of a sweep, then assert reset at cycle 30 -> start has no effect; after reset all outputs=0 and state is IDLE. A new start gives a clean 64-cycle sweep with pass=1.
- SETTLE=3, correct CUT, sample pattern each cycle -> each value is held exactly 4 cycles; done at edge 128; a second start from DONE clears err_count and repeats the sweep.
